// File: rtl/lsu_ctrl.sv
// Load/store unit between the MEM pipeline register and the data memory.
// Misaligned half/word accesses are split into sequential byte accesses.
module lsu_ctrl #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_func3,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, ACCESS, SPLIT, RESP, ERR} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              op_we;
  logic [2:0]        op_func3;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [1:0]        k;
  logic [1:0]        last_k;
  logic [31:0]       acc;
  logic [31:0]       acc_nxt;
  logic [31:0]       result;

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return ~a[0];
      2'b10:   return (a == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Only half and word accesses are ever split, so byte loads need no case here.
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b101:  return {16'h0000, v[15:0]};
      default: return v;
    endcase
  endfunction

  assign last_k = (op_func3[1:0] == 2'b10) ? 2'd3 :
                  (op_func3[1:0] == 2'b01) ? 2'd1 : 2'd0;

  always_comb begin
    acc_nxt = acc;
    acc_nxt[{k, 3'b000} +: 8] = mem_rdata[7:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!is_legal(req_we, req_func3))              state_nxt = ERR;
          else if (is_aligned(req_func3, req_addr[1:0])) state_nxt = ACCESS;
          else                                           state_nxt = SPLIT;
        end
      end
      ACCESS:  state_nxt = RESP;
      SPLIT:   if (k == last_k) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_we    <= 1'b0;
      op_func3 <= 3'b000;
      op_addr  <= '0;
      op_wdata <= 32'h0;
      k        <= 2'd0;
      acc      <= 32'h0;
      result   <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_we    <= req_we;
            op_func3 <= req_func3;
            op_addr  <= req_addr;
            op_wdata <= req_wdata;
            k        <= 2'd0;
            acc      <= 32'h0;
            result   <= 32'h0;
          end
        end
        ACCESS: begin
          // Memory returns LH-style data for LHU, so zero-extend locally.
          if (!op_we)
            result <= (op_func3 == 3'b101) ? {16'h0000, mem_rdata[15:0]} : mem_rdata;
        end
        SPLIT: begin
          k <= k + 2'd1;
          if (!op_we) begin
            acc <= acc_nxt;
            if (k == last_k) result <= extend(op_func3, acc_nxt);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP) || (state == ERR);
    rsp_err   = (state == ERR);
    rsp_rdata = (state == RESP) ? result : 32'h0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_func3 = 3'b000;
    mem_wdata = 32'h0;
    case (state)
      ACCESS: begin
        mem_read  = ~op_we;
        mem_write = op_we;
        mem_addr  = op_addr;
        mem_wdata = op_wdata;
        mem_func3 = (!op_we && op_func3 == 3'b101) ? 3'b001 : op_func3;
      end
      SPLIT: begin
        mem_read  = ~op_we;
        mem_write = op_we;
        mem_addr  = op_addr + ADDR_W'(k);
        mem_func3 = op_we ? 3'b000 : 3'b100;
        mem_wdata = op_we ? {24'h000000, op_wdata[{k, 3'b000} +: 8]} : 32'h0;
      end
      default: ;
    endcase
  end

endmodule
